// File: rtl/rv32_instr_encoder_if.sv
// Request and instruction-memory write bus of the RV32I instruction encoder.
// The slave side is the encoder; the master side is the loader feeding it and the memory acking it.
interface rv32_instr_encoder_if #(
    parameter int ADDR_W = 8
) ();
    logic              req_valid;
    logic              req_ready;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;

    modport slave (
        input  req_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, mem_ack,
        output req_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, mem_ack,
        input  req_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/rv32_instr_encoder.sv
// Encodes RV32I instruction fields into 32-bit words and writes them to instruction memory
// at an auto-incrementing word address; illegal opcodes and unencodable immediates are flagged.
module rv32_instr_encoder #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    rv32_instr_encoder_if.slave     bus,
    output logic [15:0]             instr_count,
    output logic                    err_illegal,
    output logic                    err_imm
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {IDLE, ENC, WRITE} state_t;

    state_t            state, state_nxt;
    logic [6:0]        op_q;
    logic [4:0]        rd_q, rs1_q, rs2_q;
    logic [2:0]        f3_q;
    logic [6:0]        f7_q;
    logic [31:0]       imm_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word;
    logic              bad_op, bad_imm, accept;
    logic              i_fits, b_fits, j_fits;

    assign bus.req_ready = (state == IDLE) && !clear;
    assign bus.mem_we    = (state == WRITE);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign accept        = bus.req_valid && bus.req_ready;

    // Range checks as sign-extension tests: all bits above the field's sign bit must match it.
    assign i_fits = (imm_q[31:11] == '0) || (imm_q[31:11] == '1);
    assign b_fits = ((imm_q[31:12] == '0) || (imm_q[31:12] == '1)) && !imm_q[0];
    assign j_fits = ((imm_q[31:20] == '0) || (imm_q[31:20] == '1)) && !imm_q[0];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ENC;
            ENC:     state_nxt = (bad_op || bad_imm) ? IDLE : WRITE;
            WRITE:   if (bus.mem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        word    = '0;
        bad_op  = 1'b0;
        bad_imm = 1'b0;
        case (op_q)
            OP_R: word = {f7_q, rs2_q, rs1_q, f3_q, rd_q, op_q};
            OP_IMM: begin
                if (f3_q == 3'b001 || f3_q == 3'b101) begin
                    word    = {f7_q, imm_q[4:0], rs1_q, f3_q, rd_q, op_q};
                    bad_imm = (imm_q[31:5] != '0);
                end else begin
                    word    = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
                    bad_imm = !i_fits;
                end
            end
            OP_LOAD, OP_JALR: begin
                word    = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
                bad_imm = !i_fits;
            end
            OP_STORE: begin
                word    = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], op_q};
                bad_imm = !i_fits;
            end
            OP_BRANCH: begin
                word    = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q, imm_q[4:1], imm_q[11], op_q};
                bad_imm = !b_fits;
            end
            OP_LUI, OP_AUIPC: begin
                word    = {imm_q[31:12], rd_q, op_q};
                bad_imm = (imm_q[11:0] != '0);
            end
            OP_JAL: begin
                word    = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, op_q};
                bad_imm = !j_fits;
            end
            default: bad_op = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= bus.opcode;
            rd_q  <= bus.rd;
            rs1_q <= bus.rs1;
            rs2_q <= bus.rs2;
            f3_q  <= bus.funct3;
            f7_q  <= bus.funct7;
            imm_q <= bus.imm;
        end
    end

    // Address and count only move on an acknowledged write, or on clear while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= BASE_ADDR;
            wdata_q     <= '0;
            instr_count <= '0;
            err_illegal <= 1'b0;
            err_imm     <= 1'b0;
        end else begin
            err_illegal <= (state == ENC) && bad_op;
            err_imm     <= (state == ENC) && bad_imm;
            if (state == IDLE && clear) begin
                addr_q      <= BASE_ADDR;
                instr_count <= '0;
            end
            if (state == ENC && !bad_op && !bad_imm) wdata_q <= word;
            if (state == WRITE && bus.mem_ack) begin
                addr_q <= addr_q + 1'b1;
                if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Self-checking bench for rv32_instr_encoder: a wide instance (ADDR_W=8, BASE 0) and a narrow
// one (ADDR_W=2, BASE 1) share all stimulus and are checked every cycle against a field-level model.
module tb_rv32_instr_encoder;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic        clk = 1'b0;
    logic        reset, clear;
    logic [15:0] countA, countB;
    logic        errIllA, errImmA, errIllB, errImmB;

    int checks = 0;
    int passes = 0;
    bit checkEn = 1'b0;

    logic        expReady, expWe, expIll, expImm;
    logic [31:0] expWdata;
    int          expAddrA, expAddrB, expCount;

    rv32_instr_encoder_if #(.ADDR_W(8)) bus ();
    rv32_instr_encoder_if #(.ADDR_W(2)) busB ();

    assign busB.req_valid = bus.req_valid;
    assign busB.opcode    = bus.opcode;
    assign busB.rd        = bus.rd;
    assign busB.rs1       = bus.rs1;
    assign busB.rs2       = bus.rs2;
    assign busB.funct3    = bus.funct3;
    assign busB.funct7    = bus.funct7;
    assign busB.imm       = bus.imm;
    assign busB.mem_ack   = bus.mem_ack;

    rv32_instr_encoder #(.ADDR_W(8), .BASE_ADDR(8'd0)) dut (
        .clk(clk), .reset(reset), .clear(clear), .bus(bus),
        .instr_count(countA), .err_illegal(errIllA), .err_imm(errImmA)
    );

    rv32_instr_encoder #(.ADDR_W(2), .BASE_ADDR(2'd1)) dutB (
        .clk(clk), .reset(reset), .clear(clear), .bus(busB),
        .instr_count(countB), .err_illegal(errIllB), .err_imm(errImmB)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        else             passes++;
    endtask

    // Reference encoding from the format table; status 0 = legal, 1 = bad opcode, 2 = bad immediate.
    function automatic void encodeModel(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                                        input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [31:0] imm, output int status,
                                        output logic [31:0] word);
        int s;
        s      = $signed(imm);
        status = 0;
        word   = '0;
        if (op == OP_R) begin
            word = {f7, rs2, rs1, f3, rd, op};
        end else if (op == OP_IMM && (f3 == 3'd1 || f3 == 3'd5)) begin
            if (s < 0 || s > 31) status = 2;
            word = {f7, imm[4:0], rs1, f3, rd, op};
        end else if (op == OP_IMM || op == OP_LOAD || op == OP_JALR) begin
            if (s < -2048 || s > 2047) status = 2;
            word = {imm[11:0], rs1, f3, rd, op};
        end else if (op == OP_STORE) begin
            if (s < -2048 || s > 2047) status = 2;
            word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        end else if (op == OP_BRANCH) begin
            if (s < -4096 || s > 4094 || (s % 2) != 0) status = 2;
            word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        end else if (op == OP_LUI || op == OP_AUIPC) begin
            if ((imm % 4096) != 0) status = 2;
            word = {imm[31:12], rd, op};
        end else if (op == OP_JAL) begin
            if (s < -(1 << 20) || s > (1 << 20) - 2 || (s % 2) != 0) status = 2;
            word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        end else begin
            status = 1;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pinModel(input string name, input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                            input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                            input int expStatus, input logic [31:0] expWord);
        int st;
        logic [31:0] w;
        encodeModel(op, rd, rs1, rs2, f3, f7, imm, st, w);
        checkOutput({name, "_status"}, 32'(st), 32'(expStatus));
        if (expStatus == 0) checkOutput({name, "_word"}, w, expWord);
    endtask

    // One full request: accept, encode, then either an error pulse or a write acked after ackDelay cycles.
    task automatic applyStimulus(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                                 input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                                 input int ackDelay, input bit clearInWrite);
        int st;
        logic [31:0] w;
        encodeModel(op, rd, rs1, rs2, f3, f7, imm, st, w);
        bus.req_valid = 1'b1;
        bus.opcode = op; bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2;
        bus.funct3 = f3; bus.funct7 = f7; bus.imm = imm;
        step();
        bus.req_valid = 1'b0;
        expReady = 1'b0;
        step();
        if (st != 0) begin
            expIll = (st == 1);
            expImm = (st == 2);
            expReady = 1'b1;
            step();
            expIll = 1'b0;
            expImm = 1'b0;
        end else begin
            expWe = 1'b1;
            expWdata = w;
            for (int i = 0; i < ackDelay; i++) begin
                clear = clearInWrite;
                step();
            end
            clear = 1'b0;
            bus.mem_ack = 1'b1;
            step();
            bus.mem_ack = 1'b0;
            expWe = 1'b0;
            expAddrA = (expAddrA + 1) % 256;
            expAddrB = (expAddrB + 1) % 4;
            if (expCount != 65535) expCount++;
            expReady = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("A_req_ready", 32'(bus.req_ready), 32'(expReady));
            checkOutput("A_mem_we", 32'(bus.mem_we), 32'(expWe));
            checkOutput("A_mem_addr", 32'(bus.mem_addr), 32'(expAddrA));
            checkOutput("A_mem_wdata", bus.mem_wdata, expWdata);
            checkOutput("A_instr_count", 32'(countA), 32'(expCount));
            checkOutput("A_err_illegal", 32'(errIllA), 32'(expIll));
            checkOutput("A_err_imm", 32'(errImmA), 32'(expImm));
            checkOutput("B_req_ready", 32'(busB.req_ready), 32'(expReady));
            checkOutput("B_mem_we", 32'(busB.mem_we), 32'(expWe));
            checkOutput("B_mem_addr", 32'(busB.mem_addr), 32'(expAddrB));
            checkOutput("B_mem_wdata", busB.mem_wdata, expWdata);
            checkOutput("B_instr_count", 32'(countB), 32'(expCount));
            checkOutput("B_err_illegal", 32'(errIllB), 32'(expIll));
            checkOutput("B_err_imm", 32'(errImmB), 32'(expImm));
        end
    end

    initial begin
        int st;
        logic [31:0] w;

        reset = 1'b1; clear = 1'b0;
        bus.req_valid = 1'b0; bus.mem_ack = 1'b0;
        bus.opcode = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0;
        bus.funct3 = '0; bus.funct7 = '0; bus.imm = '0;
        expReady = 1'b1; expWe = 1'b0; expIll = 1'b0; expImm = 1'b0;
        expWdata = '0; expAddrA = 0; expAddrB = 1; expCount = 0;
        step();
        step();
        checkEn = 1'b1;
        step();
        reset = 1'b0;
        step();

        pinModel("pin_add",  OP_R,      5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 0, 32'h002081B3);
        pinModel("pin_addi", OP_IMM,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 0, 32'h00500093);
        pinModel("pin_sw",   OP_STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 0, 32'h0020A423);
        pinModel("pin_beq",  OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 0, 32'h00000463);
        pinModel("pin_lui",  OP_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 0, 32'h123452B7);
        pinModel("pin_srai", OP_IMM,    5'd3, 5'd3, 5'd0, 3'd5, 7'b0100000, 32'd4, 0, 32'h4041D193);
        pinModel("pin_jal",  OP_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 0, 32'h001000EF);
        pinModel("pin_bodd", OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 2, 32'h0);
        pinModel("pin_ill",  7'h7F,     5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1, 32'h0);

        $display("[TB] single R-type write");
        applyStimulus(OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 0, 1'b0);
        checkOutput("t1_wdata", bus.mem_wdata, 32'h002081B3);
        checkOutput("t1_count", 32'(countA), 32'd1);

        $display("[TB] short program");
        applyStimulus(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 0, 1'b0);
        checkOutput("t2_addi", bus.mem_wdata, 32'h00500093);
        applyStimulus(OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 0, 1'b0);
        checkOutput("t2_sw", bus.mem_wdata, 32'h0020A423);
        applyStimulus(OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 0, 1'b0);
        checkOutput("t2_beq", bus.mem_wdata, 32'h00000463);
        applyStimulus(OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 0, 1'b0);
        checkOutput("t2_lui", bus.mem_wdata, 32'h123452B7);
        checkOutput("t2_addr", 32'(bus.mem_addr), 32'd5);

        $display("[TB] error requests");
        applyStimulus(OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 0, 1'b0);
        applyStimulus(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 0, 1'b0);
        checkOutput("t3_addr", 32'(bus.mem_addr), 32'd5);
        checkOutput("t3_count", 32'(countA), 32'd5);

        $display("[TB] delayed ack with clear during write");
        applyStimulus(OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 3, 1'b1);
        checkOutput("t4_count", 32'(countA), 32'd6);

        $display("[TB] immediate boundaries");
        applyStimulus(OP_IMM,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 0, 1'b0);
        applyStimulus(OP_IMM,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 0, 1'b0);
        applyStimulus(OP_IMM,    5'd2, 5'd1, 5'd0, 3'd1, 7'd0, 32'd3, 0, 1'b0);
        applyStimulus(OP_IMM,    5'd3, 5'd3, 5'd0, 3'd5, 7'b0100000, 32'd4, 1, 1'b0);
        applyStimulus(OP_IMM,    5'd2, 5'd1, 5'd0, 3'd1, 7'd0, 32'd32, 0, 1'b0);
        applyStimulus(OP_STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFFF7FF, 0, 1'b0);
        applyStimulus(OP_BRANCH, 5'd0, 5'd4, 5'd5, 3'd1, 7'd0, 32'hFFFFF000, 0, 1'b0);
        applyStimulus(OP_BRANCH, 5'd0, 5'd4, 5'd5, 3'd1, 7'd0, 32'd4094, 0, 1'b0);
        applyStimulus(OP_BRANCH, 5'd0, 5'd4, 5'd5, 3'd1, 7'd0, 32'd4096, 0, 1'b0);
        applyStimulus(OP_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF00000, 0, 1'b0);
        applyStimulus(OP_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000, 0, 1'b0);
        applyStimulus(OP_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 0, 1'b0);
        applyStimulus(OP_AUIPC,  5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000, 0, 1'b0);
        applyStimulus(OP_LOAD,   5'd7, 5'd2, 5'd0, 3'd2, 7'd0, 32'hFFFFFFFC, 0, 1'b0);
        applyStimulus(OP_JALR,   5'd0, 5'd1, 5'd0, 3'd0, 7'd0, 32'd0, 2, 1'b0);

        $display("[TB] stray ack while idle");
        bus.mem_ack = 1'b1;
        step();
        step();
        bus.mem_ack = 1'b0;
        step();

        $display("[TB] clear beats a pending request");
        bus.req_valid = 1'b1;
        bus.opcode = OP_R;
        clear = 1'b1;
        expReady = 1'b0;
        step();
        clear = 1'b0;
        bus.req_valid = 1'b0;
        expReady = 1'b1;
        expAddrA = 0;
        expAddrB = 1;
        expCount = 0;
        step();
        step();
        checkOutput("t5_count", 32'(countA), 32'd0);
        for (int i = 1; i <= 5; i++)
            applyStimulus(OP_IMM, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i), 0, 1'b0);
        checkOutput("t5_addrB", 32'(busB.mem_addr), 32'd2);
        checkOutput("t5_addrA", 32'(bus.mem_addr), 32'd5);

        $display("[TB] reset during write");
        encodeModel(OP_IMM, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9, st, w);
        bus.req_valid = 1'b1;
        bus.opcode = OP_IMM; bus.rd = 5'd9; bus.rs1 = 5'd0; bus.rs2 = 5'd0;
        bus.funct3 = 3'd0; bus.funct7 = 7'd0; bus.imm = 32'd9;
        step();
        bus.req_valid = 1'b0;
        expReady = 1'b0;
        step();
        expWe = 1'b1;
        expWdata = w;
        step();
        reset = 1'b1;
        step();
        expWe = 1'b0; expReady = 1'b1; expWdata = '0;
        expAddrA = 0; expAddrB = 1; expCount = 0;
        reset = 1'b0;
        step();
        checkOutput("t6_we", 32'(bus.mem_we), 32'd0);
        step();
        checkEn = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
